// File: rtl/ls_store_buffer_pkg.sv
// Shared memory-access encodings and helpers for the load/store front-end.
package ls_store_buffer_pkg;

    localparam logic [1:0] MODE_WORD = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    // Reserved mode counts as misaligned so it is dropped rather than issued.
    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] addr_lo);
        logic bad;
        unique case (mode)
            MODE_WORD: bad = (addr_lo != 2'b00);
            MODE_HALF: bad = addr_lo[0];
            MODE_BYTE: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Number of significant bits in a loaded value; 0 means no extension needed.
    function automatic int ext_width(input logic [1:0] mode);
        int w;
        unique case (mode)
            MODE_BYTE: w = 8;
            MODE_HALF: w = 16;
            default:   w = 0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/ls_store_buffer_sb.sv
// Register FIFO of pending stores with a per-entry word-address compare (hit vector).
module sb_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AWIDTH = 12,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              push,
    input  logic [1:0]        push_mode,
    input  logic [AWIDTH-1:0] push_addr,
    input  logic [DWIDTH-1:0] push_wdata,
    input  logic              pop,
    output logic [1:0]        head_mode,
    output logic [AWIDTH-1:0] head_addr,
    output logic [DWIDTH-1:0] head_wdata,
    output logic              full,
    output logic              empty,
    input  logic [AWIDTH-3:0] cmp_waddr,
    output logic [DEPTH-1:0]  hit_vec
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]     head_q, tail_q;
    logic [CW-1:0]     count_q, count_d;
    logic [DEPTH-1:0]  valid_q;
    logic [1:0]        mode_q  [DEPTH];
    logic [AWIDTH-1:0] addr_q  [DEPTH];
    logic [DWIDTH-1:0] wdata_q [DEPTH];

    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    assign head_mode  = mode_q[head_q];
    assign head_addr  = addr_q[head_q];
    assign head_wdata = wdata_q[head_q];

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit_vec[i] = valid_q[i] && (addr_q[i][AWIDTH-1:2] == cmp_waddr);
        end
    end

    // When full, push and pop target the same slot; the push's valid set is the later NBA.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mode_q[tail_q]  <= push_mode;
            addr_q[tail_q]  <= push_addr;
            wdata_q[tail_q] <= push_wdata;
        end
    end

endmodule

// File: rtl/ls_store_buffer.sv
// Load/store front-end: queues stores, drains them when the memory port is idle, returns
// extended registered load data and drops misaligned requests.
module ls_store_buffer
    import ls_store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned AWIDTH = 12,
    parameter int unsigned DWIDTH = 32
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_mode,
    input  logic              req_sign,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              req_stall,
    input  logic              flush,
    output logic              ld_valid,
    output logic [DWIDTH-1:0] ld_data,
    output logic              misalign,
    output logic              sb_empty,
    output logic              mem_str,
    output logic [1:0]        mem_mode,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_din,
    input  logic [DWIDTH-1:0] mem_dout
);

    logic              mis_req, load_req, store_req;
    logic              load_stall, store_stall, flush_block;
    logic              load_go, store_go, drain, hit;
    logic              full, empty;
    logic [DEPTH-1:0]  hit_vec;
    logic [1:0]        head_mode;
    logic [AWIDTH-1:0] head_addr;
    logic [DWIDTH-1:0] head_wdata;
    logic [DWIDTH-1:0] ext_data;
    logic              sign_bit;
    int                ext_w;

    logic              ld_valid_q, misalign_q;
    logic [DWIDTH-1:0] ld_data_q;

    sb_fifo #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH),
        .DWIDTH (DWIDTH)
    ) u_sb_fifo (
        .clk        (clk),
        .clr        (clr),
        .push       (store_go),
        .push_mode  (req_mode),
        .push_addr  (req_addr),
        .push_wdata (req_wdata),
        .pop        (drain),
        .head_mode  (head_mode),
        .head_addr  (head_addr),
        .head_wdata (head_wdata),
        .full       (full),
        .empty      (empty),
        .cmp_waddr  (req_addr[AWIDTH-1:2]),
        .hit_vec    (hit_vec)
    );

    assign hit         = |hit_vec;
    assign flush_block = flush && !empty;

    always_comb begin
        mis_req     = req_valid && is_misaligned(req_mode, req_addr[1:0]);
        load_req    = req_valid && !mis_req && !req_we;
        store_req   = req_valid && !mis_req && req_we;
        load_stall  = load_req && (hit || flush_block);
        load_go     = load_req && !load_stall;
        // Loads own the port; otherwise any queued store drains, which frees a slot for a store.
        drain       = !empty && !load_go;
        store_stall = store_req && (flush_block || (full && !drain));
        store_go    = store_req && !store_stall;
        req_stall   = load_stall || store_stall;
    end

    assign sb_empty = empty;
    assign mem_str  = drain;
    assign mem_mode = load_go ? req_mode : head_mode;
    assign mem_addr = load_go ? req_addr : head_addr;
    assign mem_din  = head_wdata;

    always_comb begin
        ext_w = ext_width(req_mode);
        unique case (req_mode)
            MODE_BYTE: sign_bit = req_sign && mem_dout[7];
            MODE_HALF: sign_bit = req_sign && mem_dout[15];
            default:   sign_bit = 1'b0;
        endcase
        ext_data = mem_dout;
        if (ext_w != 0) begin
            for (int i = 0; i < DWIDTH; i++) begin
                if (i >= ext_w) begin
                    ext_data[i] = sign_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ld_valid_q <= 1'b0;
            ld_data_q  <= '0;
            misalign_q <= 1'b0;
        end else begin
            ld_valid_q <= load_go;
            misalign_q <= mis_req;
            if (load_go) begin
                ld_data_q <= ext_data;
            end
        end
    end

    assign ld_valid = ld_valid_q;
    assign ld_data  = ld_data_q;
    assign misalign = misalign_q;

endmodule
